pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage MIPS core. It drives the write-enable and flush inputs of the PC, the IF/ID register and the ID/EX register, which holds the wb/m/ex control fields, PC+4, the two register read values, the sign-extended immediate, rt and rd. It handles three cases:
- load-use stalls
- taken-branch squashes
- interlocks against a multi-cycle multiply/divide unit (MDU) tracked by an internal countdown.

Parameters:
MDU_CYCLES, 32, latency of MDU operation in cycles from mdu_start (legal range 2..255)
CNT_W, 8, width of MDU countdown register

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rs  input  1  ID instruction reads rs
id_uses_rt  input  1  ID instruction reads rt
id_uses_hilo  input  1  ID instruction is MFHI/MFLO/MULT/DIV (needs MDU idle)
ex_memread  input  1  instruction in EX is a load (ID/EX m-field memread bit)
ex_rt  input  5  destination rt of instruction in EX
ex_branch_taken  input  1  branch/jump in EX resolved taken
mdu_start  input  1  MDU op issued from EX this cycle
pc_we  output  1  PC write enable
ifid_we  output  1  IF/ID register write enable
ifid_flush  output  1  clear IF/ID to NOP (dominates ifid_we)
idex_flush  output  1  load zero bubble into ID/EX (all 147 bits 0)
mdu_busy  output  1  MDU countdown active
stall  output  1  front-end stalled this cycle (pc_we==0 due to hazard)

Behaviour:
- State register: RUN, MDU_BUSY. Countdown register cnt[CNT_W-1:0].
- Outputs are combinational from current state and inputs. Hazard response therefore takes effect in the same cycle: zero latency.
- While rst=1: pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1, stall=0. mdu_busy reflects state, which is RUN after the first clk edge with rst=1, and cnt=0.
- Load-use hazard, lu:
  - lu = ex_memread && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
  - Register $0 never causes a hazard.
- MDU hazard, mh: mh = (state==MDU_BUSY) && id_uses_hilo.
- Priority: ex_branch_taken > (lu | mh) > normal.
  - Branch taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_flush=1, stall=0. The squashed ID instruction's hazard is ignored.
  - lu or mh: pc_we=0, ifid_we=0, ifid_flush=0, idex_flush=1, stall=1.
  - Otherwise: pc_we=1, ifid_we=1, ifid_flush=0, idex_flush=0, stall=0.
- Load-use stall lasts exactly 1 cycle: the bubble moves the load out of EX.
- State transitions:
  - RUN: mdu_start=1 -> MDU_BUSY, cnt<=MDU_CYCLES-1.
  - MDU_BUSY: cnt decrements each cycle. On the edge where cnt==1 -> RUN, cnt<=0.
  - Result: mdu_busy is high for exactly MDU_CYCLES-1 cycles after the mdu_start cycle.
  - mdu_start while in MDU_BUSY: ignored, with no restart and no extension. The interlock makes this impossible in legal code.
- Branch taken during MDU_BUSY: flush proceeds and the countdown continues unaffected.
- rst asserted mid-MDU_BUSY: next edge returns to RUN, cnt=0, mdu_busy=0.
- lu and mh in the same cycle: a single stall cycle is produced. mh continues to stall until RUN.

Optional Feature:
HAZ_STATS_EN
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0], both 0 on rst.
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with ex_branch_taken=1 and rst=0.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=1, mdu_busy=0. Release -> pc_we=1, no flush.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle -> stall=1, idex_flush=1, pc_we=0 that cycle only. Repeat with ex_rt=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 with the load-use condition above true -> ifid_flush=1, idex_flush=1, pc_we=1, stall=0.
- MDU interlock: MDU_CYCLES=4, pulse mdu_start -> mdu_busy high for 3 cycles. id_uses_hilo=1 throughout -> stall=1 exactly in those 3 cycles, then released. A second mdu_start mid-busy does not extend.
- Reset mid-MDU: rst=1 on second busy cycle -> mdu_busy=0 next cycle and no further stall.
- With HAZ_STATS_EN: 3 load-use stalls + 2 branches -> stall_cnt=3, flush_cnt=2. Force stall for 70000 cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS core: load-use stalls, branch squashes, MDU interlock.
// Optional HAZ_STATS_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_uses_hilo,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       mdu_start,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       mdu_busy,
  output logic       stall
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic [0:0] {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu, mh;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A start while busy is dropped: legal code is interlocked away from it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (mdu_start) begin
          state_nxt = MDU_BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      MDU_BUSY: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Register $0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu = ex_memread && (ex_rt != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  assign mh = (state == MDU_BUSY) && id_uses_hilo;

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall      = 1'b0;
    mdu_busy   = (state == MDU_BUSY);
    if (rst) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu || mh) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
      stall      = 1'b1;
    end
  end

`ifdef HAZ_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)           stall_cnt <= sat_inc(stall_cnt);
      if (ex_branch_taken) flush_cnt <= sat_inc(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, MDU/reset sequences, randomized model compare.
module tb_pipe_hazard_ctrl;
  localparam int MDU_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic       id_uses_rs = 0, id_uses_rt = 0, id_uses_hilo = 0;
  logic       ex_memread = 0, ex_branch_taken = 0, mdu_start = 0;
  logic       pc_we, ifid_we, ifid_flush, idex_flush, mdu_busy, stall;
`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_uses_hilo(id_uses_hilo), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mdu_start(mdu_start),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mdu_busy(mdu_busy), .stall(stall)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_left = 0;  // model: remaining cycles the MDU is occupied

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, uhilo, mr;
    logic [4:0] exrt;
    logic       br;
    logic [4:0] exp;  // {pc_we, ifid_we, ifid_flush, idex_flush, stall}
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0;
    ex_memread = 0; ex_branch_taken = 0; mdu_start = 0;
  endtask

  // Expected outputs straight from the hazard rules and the model's MDU occupancy.
  task automatic check_model(input string tag);
    logic lu, mh;
    logic [4:0] e;
    lu = ex_memread && ex_rt != 0 &&
         ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    mh = (busy_left > 0) && id_uses_hilo;
    if (rst)                  e = 5'b00110;
    else if (ex_branch_taken) e = 5'b11110;
    else if (lu || mh)        e = 5'b00011;
    else                      e = 5'b11000;
    chk({tag, ".outs"}, {11'd0, pc_we, ifid_we, ifid_flush, idex_flush, stall}, {11'd0, e});
    chk({tag, ".mdu_busy"}, {15'd0, mdu_busy}, {15'd0, busy_left > 0});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst)                busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (mdu_start)     busy_left = MDU_CYCLES - 1;
    #1;
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    check_model(tag);
    tick();
  endtask

  initial begin
    int n;
    vecs[0] = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'b11000};  // nothing
    vecs[1] = '{5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 5'b00011};  // load-use on rs
    vecs[2] = '{5'd0, 5'd0, 1, 1, 0, 1, 5'd0, 0, 5'b11000};  // $0 never hazards
    vecs[3] = '{5'd1, 5'd5, 0, 1, 0, 1, 5'd5, 0, 5'b00011};  // load-use on rt
    vecs[4] = '{5'd8, 5'd0, 0, 0, 0, 1, 5'd8, 0, 5'b11000};  // rs matches but unused
    vecs[5] = '{5'd8, 5'd8, 1, 1, 0, 0, 5'd8, 0, 5'b11000};  // not a load
    vecs[6] = '{5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 1, 5'b11110};  // branch beats load-use
    vecs[7] = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 5'b11110};  // plain branch
    vecs[8] = '{5'd0, 5'd0, 0, 0, 1, 0, 5'd0, 0, 5'b11000};  // hilo use with MDU idle
    vecs[9] = '{5'd7, 5'd6, 1, 1, 0, 1, 5'd8, 0, 5'b11000};  // no register match

    // Reset held 2 cycles
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst.outs", {11'd0, pc_we, ifid_we, ifid_flush, idex_flush, stall}, 16'b00110);
      chk("rst.mdu_busy", {15'd0, mdu_busy}, 16'd0);
      tick();
    end
    rst = 0;
    @(negedge clk);
    chk("rel.outs", {11'd0, pc_we, ifid_we, ifid_flush, idex_flush, stall}, 16'b11000);
    tick();

    // Vector table, MDU idle
    foreach (vecs[i]) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt; id_uses_hilo = vecs[i].uhilo;
      ex_memread = vecs[i].mr; ex_rt = vecs[i].exrt; ex_branch_taken = vecs[i].br;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {11'd0, pc_we, ifid_we, ifid_flush, idex_flush, stall},
          {11'd0, vecs[i].exp});
      tick();
    end
    idle_inputs();

    // MDU interlock with a restart attempt mid-busy
    id_uses_hilo = 1;
    for (int i = 0; i < 6; i++) begin
      mdu_start = (i == 0 || i == 2);
      @(negedge clk);
      chk($sformatf("mdu.stall%0d", i), {15'd0, stall}, {15'd0, i >= 1 && i <= 3});
      chk($sformatf("mdu.busy%0d", i), {15'd0, mdu_busy}, {15'd0, i >= 1 && i <= 3});
      tick();
    end
    idle_inputs();

    // Busy-length count, bounded wait
    mdu_start = 1;
    tick();
    mdu_start = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mdu_busy) n++;
      tick();
    end
    chk("mdu.len", 16'(n), 16'(MDU_CYCLES - 1));

    // Branch during busy: flush, countdown continues
    mdu_start = 1; tick(); mdu_start = 0;
    ex_branch_taken = 1; id_uses_hilo = 1;
    step("brbusy");
    ex_branch_taken = 0;
    for (int i = 0; i < 4; i++) step("brbusy.after");

    // Reset on the second busy cycle
    idle_inputs();
    id_uses_hilo = 1;
    mdu_start = 1; tick(); mdu_start = 0;
    step("rstmid.b1");
    rst = 1;
    @(negedge clk);
    chk("rstmid.outs", {11'd0, pc_we, ifid_we, ifid_flush, idex_flush, stall}, 16'b00110);
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid.busy", {15'd0, mdu_busy}, 16'd0);
      chk("rstmid.stall", {15'd0, stall}, 16'd0);
      tick();
    end

    // Randomized run against the model
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); id_uses_hilo = 1'($urandom);
      ex_memread = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 99) < 15);
      mdu_start = ($urandom_range(0, 99) < 10);
      step("rand");
    end

`ifdef HAZ_STATS_EN
    idle_inputs();
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    chk("stats.rst_stall", stall_cnt, 16'd0);
    chk("stats.rst_flush", flush_cnt, 16'd0);
    for (int i = 0; i < 3; i++) begin
      ex_memread = 1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1;
      tick();
      idle_inputs();
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      ex_branch_taken = 1; tick();
      ex_branch_taken = 0; tick();
    end
    @(negedge clk);
    chk("stats.stall_cnt", stall_cnt, 16'd3);
    chk("stats.flush_cnt", flush_cnt, 16'd2);
    ex_memread = 1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    chk("stats.sat", stall_cnt, 16'hFFFF);
    idle_inputs();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
